// File: rtl/regfile_pkg.sv
// Shared processor constants for the register file: default sizes and the
// hard-wired zero register index.
package regfile_pkg;

  localparam int unsigned RF_WIDTH    = 32;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_ADDR_W   = $clog2(RF_DEPTH);
  localparam int unsigned RF_ZERO_REG = 0;

endpackage : regfile_pkg

// File: rtl/regfile_entry.sv
// One architectural register: WIDTH-bit storage with write enable and
// asynchronous active-low clear.
module regfile_entry #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule : regfile_entry

// File: rtl/regfile.sv
// Two-read, one-write register file with write-first bypass, a hard-wired
// zero register and per-register pending (scoreboard) bits.
module regfile
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH  = RF_WIDTH,
  parameter  int unsigned DEPTH  = RF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              ctrl_issue,
  input  logic [ADDR_W-1:0] ctrl_issueReg,
  output logic              busy_A,
  output logic              busy_B
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_REG);

  logic             wr_hit;
  logic             iss_hit;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] rd_a_d;
  logic [WIDTH-1:0] rd_b_d;
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  assign wr_hit  = ctrl_writeEnable && (ctrl_writeReg != ZERO_IDX);
  assign iss_hit = ctrl_issue && (ctrl_issueReg != ZERO_IDX);

  // Register 0 has no storage; it always reads as zero.
  assign entry_q[0] = '0;

  for (genvar k = 1; k < DEPTH; k++) begin : g_entry
    regfile_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk   (clk),
      .rst_n (reset),
      .we    (wr_hit && (ctrl_writeReg == ADDR_W'(k))),
      .d     (data_writeReg),
      .q     (entry_q[k])
    );
  end

  // Read muxes with write-first bypass, and pending-bit next state (set wins).
  always_comb begin
    rd_a_d = entry_q[ctrl_readRegA];
    rd_b_d = entry_q[ctrl_readRegB];
    pend_d = pend_q;
    if (wr_hit && (ctrl_writeReg == ctrl_readRegA)) begin
      rd_a_d = data_writeReg;
    end
    if (wr_hit && (ctrl_writeReg == ctrl_readRegB)) begin
      rd_b_d = data_writeReg;
    end
    if (wr_hit) begin
      pend_d[ctrl_writeReg] = 1'b0;
    end
    if (iss_hit) begin
      pend_d[ctrl_issueReg] = 1'b1;
    end
    pend_d[RF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_readRegA <= '0;
      data_readRegB <= '0;
      pend_q        <= '0;
    end else begin
      data_readRegA <= rd_a_d;
      data_readRegB <= rd_b_d;
      pend_q        <= pend_d;
    end
  end

  // A source stops being busy as soon as its producer writes back this cycle.
  assign busy_A = pend_q[ctrl_readRegA] &
                  ~(ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegA));
  assign busy_B = pend_q[ctrl_readRegB] &
                  ~(ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegB));

endmodule : regfile

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expectations from an
// array-based model, a monitor pops and compares them.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] rda;
  logic [31:0] rdb;
  logic        iss;
  logic [4:0]  ir;
  logic        busy_a;
  logic        busy_b;

  regfile dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (rda),
    .data_readRegB    (rdb),
    .ctrl_issue       (iss),
    .ctrl_issueReg    (ir),
    .busy_A           (busy_a),
    .busy_B           (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        busy_q[$];
  exp_t        read_q[$];
  logic [31:0] mem  [32];
  logic        pend [32];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'h0;
      pend[i] = 1'b0;
    end
  endtask

  // One clock of stimulus; expectations come from the architectural model.
  task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] d, input logic [4:0] a, input logic [4:0] b,
                       input logic i, input logic [4:0] ia);
    exp_t eb;
    exp_t er;
    @(negedge clk);
    reset = r; we = w; wr = wa; wd = d; ra = a; rb = b; iss = i; ir = ia;
    if (!r) begin
      model_reset();
      eb.a = 32'h0; eb.b = 32'h0; er.a = 32'h0; er.b = 32'h0;
    end else begin
      eb.a = 32'(pend[a] && !(w && wa == a));
      eb.b = 32'(pend[b] && !(w && wa == b));
      er.a = (w && wa != 5'd0 && wa == a) ? d : mem[a];
      er.b = (w && wa != 5'd0 && wa == b) ? d : mem[b];
      if (w && wa != 5'd0) begin
        mem[wa]  = d;
        pend[wa] = 1'b0;
      end
      if (i && ia != 5'd0) pend[ia] = 1'b1;
    end
    busy_q.push_back(eb);
    read_q.push_back(er);
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: busy settles after input change; reads appear after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (busy_q.size() > 0) begin
        e = busy_q.pop_front();
        check("busy_A", 32'(busy_a), e.a);
        check("busy_B", 32'(busy_b), e.b);
      end
      @(posedge clk);
      #1;
      if (read_q.size() > 0) begin
        e = read_q.pop_front();
        check("data_readRegA", rda, e.a);
        check("data_readRegB", rdb, e.b);
      end
    end
  end

  initial begin
    reset = 1'b0; we = 1'b0; wr = '0; wd = '0; ra = '0; rb = '0; iss = 1'b0; ir = '0;
    model_reset();
    // Reset, with traffic that must be ignored, then read A=5, B=0.
    cycle(1'b0, 1'b1, 5'd5, 32'h1111_2222, 5'd5, 5'd0, 1'b1, 5'd5);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    // Write r3 then read it back.
    cycle(1'b1, 1'b1, 5'd3, 32'h0000_00EA, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 1'b0, 5'd0);
    // Bypass on both ports.
    cycle(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, 1'b0, 5'd0);
    // Zero register: write and issue ignored.
    cycle(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    // Pending r4: busy, cleared by write, then issue+write same edge.
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);
    cycle(1'b1, 1'b1, 5'd4, 32'h4444_0004, 5'd4, 5'd3, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
    cycle(1'b1, 1'b1, 5'd4, 32'h4444_0005, 5'd4, 5'd2, 1'b1, 5'd4);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);
    // r9 written and issued, then reset asserted between edges.
    cycle(1'b1, 1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
    @(negedge clk);
    we = 1'b0; iss = 1'b0; ra = 5'd9; rb = 5'd9;
    #2;
    check("busy_A_r9_pending", 32'(busy_a), 32'(pend[9]));
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_rdA", rda, 32'h0);
    check("async_reset_rdB", rdb, 32'h0);
    check("async_reset_busy_A", 32'(busy_a), 32'h0);
    cycle(1'b0, 1'b1, 5'd9, 32'hAAAA_5555, 5'd9, 5'd9, 1'b1, 5'd9);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    // Randomized traffic concentrated on a few registers for hazards.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), rand_addr(),
            $urandom, rand_addr(), rand_addr(), ($urandom_range(0, 9) < 3), rand_addr());
    end
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile
